// File: rtl/day_of_week_engine.sv
// Multi-cycle Gregorian day-of-week engine with a bit-serial mod-400 stage.
// Optional DayOfYear output is enabled by defining DOW_DAY_OF_YEAR_EN.
module day_of_week_engine #(
  parameter int YEAR_W     = 15,
  parameter int WEEK_START = 0
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              Start,
  input  logic [6:0]        days,
  input  logic [6:0]        months,
  input  logic [YEAR_W-1:0] years,
  output logic              Busy,
  output logic              Done,
  output logic [2:0]        DayOfWeek,
  output logic              Leap,
`ifdef DOW_DAY_OF_YEAR_EN
  output logic [8:0]        DayOfYear,
  output logic              Error
`else
  output logic              Error
`endif
);

  // | state | meaning
  // | IDLE  | waiting for Start, result outputs held
  // | DIV   | one restoring division bit per cycle, (years-1) mod 400
  // | SUM   | leap flag, month offset, validity and weekday sum
  // | MOD   | reduce sum mod 7, rotate, publish result with Done
  typedef enum logic [1:0] {IDLE, DIV, SUM, MOD} stateType;

  localparam logic [2:0] WeekStart = 3'(WEEK_START);

  stateType          state;
  logic [6:0]        dayReg;
  logic [6:0]        monthReg;
  logic              yearZero;
  logic [YEAR_W-1:0] dividend;
  logic [8:0]        rem;
  logic [5:0]        bitCnt;
  logic [10:0]       sumReg;
  logic              leapReg;
  logic              errReg;
`ifdef DOW_DAY_OF_YEAR_EN
  logic [8:0]        doyReg;
`endif

  logic [9:0]  trial;
  logic [8:0]  remNext;
  logic [9:0]  remPlus1;
  logic [1:0]  c100;
  logic        leapNow;
  logic [8:0]  offsetNow;
  logic [4:0]  monthLen;
  logic        errNow;
  logic [10:0] sumNow;
  logic [2:0]  rawDow;
  logic [2:0]  rotDow;

  // 8 == 1 (mod 7), so summing octal digits preserves the residue.
  function automatic logic [2:0] mod7(input logic [10:0] s);
    logic [4:0] a;
    logic [3:0] b;
    a = 5'(s[2:0]) + 5'(s[5:3]) + 5'(s[8:6]) + 5'(s[10:9]);
    b = 4'(a[2:0]) + 4'(a[4:3]);
    return (b >= 4'd7) ? 3'(b - 4'd7) : b[2:0];
  endfunction

  always_comb begin
    trial   = {rem, dividend[YEAR_W-1]};
    remNext = (trial >= 10'd400) ? 9'(trial - 10'd400) : trial[8:0];
  end

  always_comb begin
    c100 = 2'd0;
    if (rem >= 9'd300)      c100 = 2'd3;
    else if (rem >= 9'd200) c100 = 2'd2;
    else if (rem >= 9'd100) c100 = 2'd1;

    remPlus1 = 10'(rem) + 10'd1;
    leapNow  = (remPlus1 == 10'd400) ||
               ((remPlus1[1:0] == 2'b00) && (remPlus1 != 10'd100) &&
                (remPlus1 != 10'd200) && (remPlus1 != 10'd300));

    offsetNow = 9'd0;
    monthLen  = 5'd0;
    case (monthReg)
      7'd1:  begin offsetNow = 9'd0;   monthLen = 5'd31; end
      7'd2:  begin offsetNow = 9'd31;  monthLen = leapNow ? 5'd29 : 5'd28; end
      7'd3:  begin offsetNow = 9'd59;  monthLen = 5'd31; end
      7'd4:  begin offsetNow = 9'd90;  monthLen = 5'd30; end
      7'd5:  begin offsetNow = 9'd120; monthLen = 5'd31; end
      7'd6:  begin offsetNow = 9'd151; monthLen = 5'd30; end
      7'd7:  begin offsetNow = 9'd181; monthLen = 5'd31; end
      7'd8:  begin offsetNow = 9'd212; monthLen = 5'd31; end
      7'd9:  begin offsetNow = 9'd243; monthLen = 5'd30; end
      7'd10: begin offsetNow = 9'd273; monthLen = 5'd31; end
      7'd11: begin offsetNow = 9'd304; monthLen = 5'd30; end
      7'd12: begin offsetNow = 9'd334; monthLen = 5'd31; end
      default: begin offsetNow = 9'd0; monthLen = 5'd0; end
    endcase
    if (leapNow && (monthReg > 7'd2) && (monthReg <= 7'd12))
      offsetNow = offsetNow + 9'd1;

    errNow = yearZero || (monthReg == 7'd0) || (monthReg > 7'd12) ||
             (dayReg == 7'd0) || (dayReg > 7'(monthLen));

    // 365 == 1 (mod 7): the whole-year term contributes r itself.
    sumNow = 11'(dayReg) + 11'(offsetNow) + 11'(rem) + 11'(rem >> 2) - 11'(c100);
  end

  always_comb begin
    rawDow = mod7(sumReg);
    rotDow = (rawDow >= WeekStart) ? (rawDow - WeekStart)
                                   : (rawDow + 3'd7 - WeekStart);
  end

  always_ff @(posedge Clk) begin
    if (!nReset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      DayOfWeek <= 3'd0;
      Leap      <= 1'b0;
      Error     <= 1'b0;
      dayReg    <= 7'd0;
      monthReg  <= 7'd0;
      yearZero  <= 1'b0;
      dividend  <= '0;
      rem       <= 9'd0;
      bitCnt    <= 6'd0;
      sumReg    <= 11'd0;
      leapReg   <= 1'b0;
      errReg    <= 1'b0;
`ifdef DOW_DAY_OF_YEAR_EN
      doyReg    <= 9'd0;
      DayOfYear <= 9'd0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            dayReg   <= days;
            monthReg <= months;
            yearZero <= (years == '0);
            dividend <= years - YEAR_W'(1);
            rem      <= 9'd0;
            bitCnt   <= 6'(YEAR_W);
            Busy     <= 1'b1;
            state    <= DIV;
          end
        end
        DIV: begin
          rem      <= remNext;
          dividend <= dividend << 1;
          bitCnt   <= bitCnt - 6'd1;
          if (bitCnt == 6'd1) state <= SUM;
        end
        SUM: begin
          sumReg  <= sumNow;
          leapReg <= leapNow;
          errReg  <= errNow;
`ifdef DOW_DAY_OF_YEAR_EN
          doyReg  <= offsetNow + 9'(dayReg);
`endif
          state   <= MOD;
        end
        MOD: begin
          Done      <= 1'b1;
          Busy      <= 1'b0;
          Leap      <= leapReg;
          Error     <= errReg;
          DayOfWeek <= errReg ? 3'd7 : rotDow;
`ifdef DOW_DAY_OF_YEAR_EN
          DayOfYear <= errReg ? 9'd0 : doyReg;
`endif
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
